snake_head_datapath: RTL and testbench
======================================

// Module: snake_head_datapath
// PURPOSE
//  Datapath directly downstream of the snake control FSM; consumes its ld/update/plot strobes.
//  Holds the head position and the travel direction.
//  On update, steps the head one block in the current direction, wrapping at screen edges.
//  On plot, emits the head block's pixels, one per cycle, to the VGA adapter (x, y, colour, writeEn).
// PARAMETERS
//  X_MAX    160    screen width in pixels; legal x is 0..X_MAX-1
//  Y_MAX    120    screen height in pixels; legal y is 0..Y_MAX-1
//  BLK      2      block edge in pixels; must be 2 (fixed 2x2 draw = 4 plot cycles)
//  START_X  80     head x after ld/reset (multiple of BLK)
//  START_Y  60     head y after ld/reset (multiple of BLK)
//  HEAD_COL 3'b010 colour driven during plot
// PORTS
//  clk        in   1  system clock; all state on posedge
//  rst        in   1  synchronous reset, active-high
//  ld         in   1  load start position/direction (from control)
//  update     in   1  advance head one block (from control)
//  plot       in   1  draw strobe; high for exactly 4 consecutive cycles (from control)
//  dir_in     in   2  requested direction: 00 up, 01 down, 10 left, 11 right
//  dir_valid  in   1  one-cycle qualifier for dir_in (debounced key edge)
//  x          out  8  pixel x to VGA adapter
//  y          out  7  pixel y to VGA adapter
//  colour     out  3  pixel colour
//  writeEn    out  1  pixel write enable
//  head_x     out  8  current head x (block origin)
//  head_y     out  7  current head y (block origin)
// BEHAVIOUR
//  Reset (rst=1 at posedge):
//   - head_x=START_X, head_y=START_Y; cur_dir=right, pend_dir=right.
//   - offset counter=0; x=0, y=0, colour=0, writeEn=0.
//   - Applies mid-draw too: any partially drawn block is abandoned, no further writeEn.
//  ld: same register effect as rst.
//  Priority among strobes: ld > update. plot is independent of ld/update; control never overlaps them.
//  Direction request: on dir_valid, pend_dir<=dir_in, unless dir_in is the exact reverse of cur_dir.
//   - A reverse request is dropped silently; pend_dir is left unchanged.
//   - Several dir_valid pulses between updates: the last non-reverse one wins.
//  update, on the posedge where it is sampled:
//   - Applies the reversal check against cur_dir once more.
//   - Commits the move: cur_dir<=pend_dir, then steps the head by BLK using the new direction, e.g.
//     head_x + BLK for right.
//   - dir_valid in the same cycle as update: it is NOT used for this move; it goes to pend_dir for
//     the next move.
//  Wrap-around:
//   - right: x=X_MAX-BLK -> 0; left: x=0 -> X_MAX-BLK.
//   - down: y=Y_MAX-BLK -> 0; up: y=0 -> Y_MAX-BLK.
//   - Compare before the add; no overflow past the width is allowed.
//  Draw:
//   - 2-bit offset counter: increments each cycle plot=1, cleared to 0 in any cycle plot=0.
//   - x, y, colour, writeEn are registered, 1-cycle latency after plot.
//   - Draw cycle k (k=0..3) yields x=head_x+k[0], y=head_y+k[1], colour=HEAD_COL, writeEn=1.
//   - writeEn=0, colour=0 one cycle after plot falls.
//   - plot held >4 cycles: counter wraps and the same 4 pixels repeat; no error.
//  Position is stable during plot: control never asserts update and plot in the same cycle.
//  Width rules:
//   - All additions are unsigned in 8 bits (x) and 7 bits (y).
//   - START_X/START_Y must be < X_MAX-1 / Y_MAX-1.
// STRUCTURE
//  Shared package snake_pkg holds:
//   - direction encodings DIR_UP/DIR_DOWN/DIR_LEFT/DIR_RIGHT;
//   - SCR_W=160, SCR_H=120, BLK=2;
//   - function is_reverse(a,b), shared with future body/food blocks.
//  One sub-module, snake_step_wrap: combinational next-position with wrap (pos, dir -> next pos).
//  Direction latch, offset counter and output registers stay in this module.
// TESTING
//  1. rst pulse, then ld -> head=(80,60), writeEn=0, cur_dir=right.
//  2. plot held 4 cycles -> over the next 4 cycles, writeEn=1 with (80,60),(81,60),(80,61),(81,61),
//     colour=010; then writeEn=0.
//  3. Move the head from x=158: update, dir right -> head_x=0, head_y unchanged.
//     Move up from y=0 -> head_y=118.
//  4. cur_dir=right; dir_valid with left -> ignored; next update gives head_x+2.
//     dir_valid up then left -> up taken; update gives head_y-2.
//  5. dir_valid=down in the same cycle as update (cur=right) -> this move goes right.
//     The following update goes down.
//  6. rst asserted during draw cycle 2 -> next cycle writeEn=0, head=(80,60), counter=0.
//     A fresh 4-cycle plot then redraws from offset 0.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared definitions for the snake game datapath blocks.
package snake_pkg;

    // Direction encodings; a reversal flips only bit 0 within the same axis
    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_DOWN  = 2'b01;
    localparam logic [1:0] DIR_LEFT  = 2'b10;
    localparam logic [1:0] DIR_RIGHT = 2'b11;

    localparam int unsigned SCR_W = 160;
    localparam int unsigned SCR_H = 120;
    localparam int unsigned BLK   = 2;

    // True when b is the exact opposite of a (same axis, opposite sense)
    function automatic logic is_reverse(input logic [1:0] a, input logic [1:0] b);
        return (a[1] == b[1]) && (a[0] != b[0]);
    endfunction

endpackage

// File: rtl/snake_step_wrap.sv
// Combinational next head position: one block step in dir, wrapping at screen edges.
module snake_step_wrap
    import snake_pkg::*;
#(
    parameter int unsigned X_MAX = SCR_W,
    parameter int unsigned Y_MAX = SCR_H,
    parameter int unsigned STEP  = BLK
) (
    input  logic [7:0] pos_x,
    input  logic [6:0] pos_y,
    input  logic [1:0] dir,
    output logic [7:0] nxt_x,
    output logic [6:0] nxt_y
);

    localparam logic [7:0] XLast = 8'(X_MAX - STEP);
    localparam logic [6:0] YLast = 7'(Y_MAX - STEP);
    localparam logic [7:0] XStep = 8'(STEP);
    localparam logic [6:0] YStep = 7'(STEP);

    // Edge compare happens before the add so nothing ever overflows the port width
    always_comb begin
        nxt_x = pos_x;
        nxt_y = pos_y;
        unique case (dir)
            DIR_RIGHT: nxt_x = (pos_x == XLast) ? 8'd0 : pos_x + XStep;
            DIR_LEFT:  nxt_x = (pos_x == 8'd0) ? XLast : pos_x - XStep;
            DIR_DOWN:  nxt_y = (pos_y == YLast) ? 7'd0 : pos_y + YStep;
            DIR_UP:    nxt_y = (pos_y == 7'd0) ? YLast : pos_y - YStep;
            default:   ;
        endcase
    end

endmodule

// File: rtl/snake_head_datapath.sv
// Snake head datapath: holds head position and direction, steps on update,
// and draws the 2x2 head block to the VGA adapter on plot.
module snake_head_datapath
    import snake_pkg::*;
#(
    parameter int unsigned X_MAX    = SCR_W,
    parameter int unsigned Y_MAX    = SCR_H,
    parameter int unsigned BLK      = snake_pkg::BLK,
    parameter int unsigned START_X  = 80,
    parameter int unsigned START_Y  = 60,
    parameter logic [2:0]  HEAD_COL = 3'b010
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ld,
    input  logic       update,
    input  logic       plot,
    input  logic [1:0] dir_in,
    input  logic       dir_valid,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       writeEn,
    output logic [7:0] head_x,
    output logic [6:0] head_y
);

    localparam logic [7:0] StartX = 8'(START_X);
    localparam logic [6:0] StartY = 7'(START_Y);

    logic [7:0] head_x_q, head_x_d, step_x;
    logic [6:0] head_y_q, head_y_d, step_y;
    logic [1:0] cur_dir_q, cur_dir_d;
    logic [1:0] pend_dir_q, pend_dir_d;
    logic [1:0] cnt_q, cnt_d;
    logic [7:0] x_q, x_d;
    logic [6:0] y_q, y_d;
    logic [2:0] colour_q, colour_d;
    logic       we_q, we_d;

    snake_step_wrap #(
        .X_MAX (X_MAX),
        .Y_MAX (Y_MAX),
        .STEP  (BLK)
    ) u_step (
        .pos_x (head_x_q),
        .pos_y (head_y_q),
        .dir   (cur_dir_d),
        .nxt_x (step_x),
        .nxt_y (step_y)
    );

    // Direction latch and move commit
    always_comb begin
        cur_dir_d  = cur_dir_q;
        pend_dir_d = pend_dir_q;
        head_x_d   = head_x_q;
        head_y_d   = head_y_q;
        if (update) begin
            // A stale reverse request is dropped here too; keep going straight
            if (!is_reverse(pend_dir_q, cur_dir_q)) begin
                cur_dir_d = pend_dir_q;
            end
            pend_dir_d = cur_dir_d;
            head_x_d   = step_x;
            head_y_d   = step_y;
        end
        // A request arriving with update only affects the following move
        if (dir_valid && !is_reverse(dir_in, cur_dir_q)) begin
            pend_dir_d = dir_in;
        end
    end

    // Draw sequencer: offset k gives pixel (head_x + k[0], head_y + k[1])
    always_comb begin
        cnt_d    = plot ? cnt_q + 2'd1 : 2'd0;
        x_d      = x_q;
        y_d      = y_q;
        colour_d = 3'd0;
        we_d     = 1'b0;
        if (plot) begin
            x_d      = head_x_q + {7'd0, cnt_q[0]};
            y_d      = head_y_q + {6'd0, cnt_q[1]};
            colour_d = HEAD_COL;
            we_d     = 1'b1;
        end
    end

    // State registers; ld restores exactly the reset state
    always_ff @(posedge clk) begin
        if (rst || ld) begin
            head_x_q   <= StartX;
            head_y_q   <= StartY;
            cur_dir_q  <= DIR_RIGHT;
            pend_dir_q <= DIR_RIGHT;
            cnt_q      <= 2'd0;
            x_q        <= 8'd0;
            y_q        <= 7'd0;
            colour_q   <= 3'd0;
            we_q       <= 1'b0;
        end else begin
            head_x_q   <= head_x_d;
            head_y_q   <= head_y_d;
            cur_dir_q  <= cur_dir_d;
            pend_dir_q <= pend_dir_d;
            cnt_q      <= cnt_d;
            x_q        <= x_d;
            y_q        <= y_d;
            colour_q   <= colour_d;
            we_q       <= we_d;
        end
    end

    assign x       = x_q;
    assign y       = y_q;
    assign colour  = colour_q;
    assign writeEn = we_q;
    assign head_x  = head_x_q;
    assign head_y  = head_y_q;

endmodule

// File: tb/tb_snake_head_datapath.sv
// Directed self-checking bench for snake_head_datapath.
module tb_snake_head_datapath;

    logic       clk = 1'b0;
    logic       rst, ld, update, plot, dir_valid;
    logic [1:0] dir_in;
    logic [7:0] x, head_x;
    logic [6:0] y, head_y;
    logic [2:0] colour;
    logic       writeEn;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [1:0] UP = 2'b00, DOWN = 2'b01, LEFT = 2'b10, RIGHT = 2'b11;

    snake_head_datapath dut (
        .clk       (clk),
        .rst       (rst),
        .ld        (ld),
        .update    (update),
        .plot      (plot),
        .dir_in    (dir_in),
        .dir_valid (dir_valid),
        .x         (x),
        .y         (y),
        .colour    (colour),
        .writeEn   (writeEn),
        .head_x    (head_x),
        .head_y    (head_y)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_update();
        update = 1'b1;
        tick();
        update = 1'b0;
    endtask

    task automatic req_dir(input logic [1:0] d);
        dir_in    = d;
        dir_valid = 1'b1;
        tick();
        dir_valid = 1'b0;
    endtask

    task automatic do_ld();
        ld = 1'b1;
        tick();
        ld = 1'b0;
    endtask

    // Holds plot for 4 cycles and checks the 2x2 block at (bx,by)
    task automatic draw_block(input string tag, input int bx, input int by);
        plot = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (k == 3) plot = 1'b0;
            check({tag, "_we"}, writeEn, 1);
            check({tag, "_x"}, x, bx + (k & 1));
            check({tag, "_y"}, y, by + (k >> 1));
            check({tag, "_col"}, colour, 2);
        end
        tick();
        check({tag, "_we_off"}, writeEn, 0);
        check({tag, "_col_off"}, colour, 0);
    endtask

    initial begin
        rst = 1'b1; ld = 1'b0; update = 1'b0; plot = 1'b0;
        dir_in = 2'b00; dir_valid = 1'b0;
        tick();
        tick();
        check("rst_we", writeEn, 0);
        check("rst_x", x, 0);
        check("rst_y", y, 0);
        check("rst_col", colour, 0);
        check("rst_hx", head_x, 80);
        check("rst_hy", head_y, 60);
        rst = 1'b0;

        // 1. ld gives start position
        do_ld();
        check("ld_hx", head_x, 80);
        check("ld_hy", head_y, 60);
        check("ld_we", writeEn, 0);

        // 2. 4-cycle draw
        draw_block("draw", 80, 60);

        // 3. wrap right: 39 moves reach 158, one more wraps to 0 (starting dir is right)
        for (int i = 0; i < 39; i++) do_update();
        check("pre_wrap_hx", head_x, 158);
        do_update();
        check("wrap_r_hx", head_x, 0);
        check("wrap_r_hy", head_y, 60);
        req_dir(UP);
        for (int i = 0; i < 30; i++) do_update();
        check("pre_wrap_hy", head_y, 0);
        do_update();
        check("wrap_u_hy", head_y, 118);
        check("wrap_u_hx", head_x, 0);
        // wrap left from x=0, then wrap down from y=118
        req_dir(LEFT);
        do_update();
        check("wrap_l_hx", head_x, 158);
        req_dir(DOWN);
        do_update();
        check("wrap_d_hy", head_y, 0);

        // 4. reverse requests are ignored
        do_ld();
        req_dir(LEFT);
        do_update();
        check("rev_hx", head_x, 82);
        check("rev_hy", head_y, 60);
        req_dir(UP);
        req_dir(LEFT);
        do_update();
        check("last_hx", head_x, 82);
        check("last_hy", head_y, 58);

        // 5. request alongside update applies to the next move only
        do_ld();
        dir_in = DOWN; dir_valid = 1'b1; update = 1'b1;
        tick();
        dir_valid = 1'b0; update = 1'b0;
        check("same_hx", head_x, 82);
        check("same_hy", head_y, 60);
        do_update();
        check("next_hx", head_x, 82);
        check("next_hy", head_y, 62);

        // 6. reset during draw cycle 2 abandons the block; a new draw restarts at offset 0
        plot = 1'b1;
        tick();
        check("pre_rst_x0", x, 82);
        tick();
        check("pre_rst_x1", x, 83);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        plot = 1'b0;
        check("mid_rst_we", writeEn, 0);
        check("mid_rst_col", colour, 0);
        check("mid_rst_hx", head_x, 80);
        check("mid_rst_hy", head_y, 60);
        draw_block("redraw", 80, 60);

        // plot held longer than 4 cycles repeats the same pixels
        plot = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            check("long_x", x, 80 + (k & 1));
            check("long_y", y, 60 + ((k >> 1) & 1));
        end
        plot = 1'b0;
        tick();
        check("long_we_off", writeEn, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
